// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divider.
// Holds the divider state encoding and result bus width.
package div_unit_pkg;

    localparam int DIV_DATA_W   = 32;
    localparam int DIV_RESULT_W = 2 * DIV_DATA_W;

    typedef logic [1:0] div_state_t;

    localparam div_state_t FREE    = 2'd0;
    localparam div_state_t BY_ZERO = 2'd1;
    localparam div_state_t ON      = 2'd2;
    localparam div_state_t END     = 2'd3;

    typedef logic [DIV_RESULT_W-1:0] div_result_t;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift the work register left,
// then subtract the divisor from the partial remainder when it fits.
module div_step
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic [2*DATA_W:0] work_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [2*DATA_W:0] work_o
);

    logic [2*DATA_W:0] shifted;
    logic [DATA_W:0]   top;
    logic [DATA_W:0]   dvs;
    logic [DATA_W:0]   diff;

    always_comb begin
        shifted = work_i << 1;
        top     = shifted[2*DATA_W:DATA_W];
        dvs     = {1'b0, divisor_i};
        diff    = top - dvs;
        work_o  = shifted;
        if (top >= dvs) begin
            work_o[2*DATA_W:DATA_W] = diff;
            work_o[0]               = 1'b1;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Returns {remainder, quotient} with a one-cycle ready pulse.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                annul_i,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                busy_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    div_state_t          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W:0]   work_q;
    logic [2*DATA_W:0]   work_nxt;
    logic [DATA_W-1:0]   divisor_q;
    logic                sign_q_q;
    logic                sign_r_q;
    logic [2*DATA_W-1:0] result_q;

    logic [DATA_W-1:0]   mag1;
    logic [DATA_W-1:0]   mag2;
    logic                s1;
    logic                s2;
    logic [DATA_W-1:0]   quot;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   quot_fix;
    logic [DATA_W-1:0]   rem_fix;

    div_step #(
        .DATA_W    (DATA_W)
    ) u_step (
        .work_i    (work_q),
        .divisor_i (divisor_q),
        .work_o    (work_nxt)
    );

    // Magnitudes fit in DATA_W unsigned bits, including -2^(DATA_W-1).
    always_comb begin
        s1   = signed_div_i & opdata1_i[DATA_W-1];
        s2   = signed_div_i & opdata2_i[DATA_W-1];
        mag1 = s1 ? (~opdata1_i + 1'b1) : opdata1_i;
        mag2 = s2 ? (~opdata2_i + 1'b1) : opdata2_i;
    end

    always_comb begin
        quot     = work_nxt[DATA_W-1:0];
        rem      = work_nxt[2*DATA_W-1:DATA_W];
        quot_fix = sign_q_q ? (~quot + 1'b1) : quot;
        rem_fix  = sign_r_q ? (~rem + 1'b1) : rem;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= FREE;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            sign_q_q  <= 1'b0;
            sign_r_q  <= 1'b0;
            result_q  <= '0;
        end else begin
            unique case (state_q)
                FREE: begin
                    if (start_i && !annul_i) begin
                        divisor_q <= mag2;
                        sign_q_q  <= s1 ^ s2;
                        sign_r_q  <= s1;
                        work_q    <= {{(DATA_W+1){1'b0}}, mag1};
                        cnt_q     <= '0;
                        if (opdata2_i == '0) begin
                            state_q <= BY_ZERO;
                        end else begin
                            state_q <= ON;
                        end
                    end
                end
                BY_ZERO: begin
                    if (annul_i) begin
                        state_q <= FREE;
                    end else begin
                        result_q <= '0;
                        state_q  <= END;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state_q <= FREE;
                    end else begin
                        work_q <= work_nxt;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            result_q <= {rem_fix, quot_fix};
                            state_q  <= END;
                        end
                    end
                end
                END: begin
                    state_q <= FREE;
                end
                default: begin
                    state_q <= FREE;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = (state_q == END);
    assign busy_o   = (state_q != FREE);

endmodule
